// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: ALU operand widths, op encodings, writeback entry.
// Pure declarations; no timing or flow control of its own.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        OP_OR  = 3'd0,
        OP_AND = 3'd1,
        OP_XOR = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_MUL = 3'd5
    } alu_op_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_queue_if.sv
// Bundle of ALU-result input, register-file write port and forwarding query.
// Valid/ready on both the input and the writeback side; forwarding is combinational.
interface alu_wb_queue_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rd;
    logic [DATA_W-1:0] in_data;
    logic              wb_valid;
    logic              wb_ready;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [REG_AW-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, in_valid, in_rd, in_data, wb_ready, fwd_addr,
        input  in_ready, wb_valid, wb_addr, wb_data, fwd_hit, fwd_data, count
    );

    modport slave (
        input  flush, in_valid, in_rd, in_data, wb_ready, fwd_addr,
        output in_ready, wb_valid, wb_addr, wb_data, fwd_hit, fwd_data, count
    );

endinterface

// File: rtl/wb_queue_mem.sv
// DEPTH x wb_entry_t register array: one write port, one read port, and a parallel
// rd-compare vector for the forward search. Write lands on the next edge; reads are combinational.
module wb_queue_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  wb_entry_t         wdata,
    input  logic [PTR_W-1:0]  raddr,
    output wb_entry_t         rdata,
    input  logic [REG_AW-1:0] fwd_addr,
    output logic [DEPTH-1:0]  match,
    output wb_entry_t         entries [DEPTH]
);

    wb_entry_t mem [DEPTH];

    // Storage needs no reset: occupancy is tracked by the controller's count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i]   = (mem[i].rd == fwd_addr);
            entries[i] = mem[i];
        end
    end

endmodule

// File: rtl/alu_wb_queue.sv
// In-order queue from ALU result to register-file write port, with youngest-match forwarding.
// Latency 1 cycle in to wb_valid; a full queue still accepts when the head drains the same cycle.
module alu_wb_queue
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_wb_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             empty;
    wb_entry_t        wdata;
    wb_entry_t        head;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] match;

    assign empty        = (count == '0);
    assign bus.wb_valid = !empty;
    assign pop          = bus.wb_valid && bus.wb_ready;
    assign bus.in_ready = (count < CNT_W'(DEPTH)) || pop;
    // r0 writes are accepted but never stored; flush drops any same-cycle enqueue.
    assign push         = bus.in_valid && bus.in_ready && (bus.in_rd != '0) && !bus.flush;
    assign bus.count    = count;

    assign wdata.rd   = bus.in_rd;
    assign wdata.data = bus.in_data;

    wb_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
        .clk      (clk),
        .we       (push),
        .waddr    (wr_ptr),
        .wdata    (wdata),
        .raddr    (rd_ptr),
        .rdata    (head),
        .fwd_addr (bus.fwd_addr),
        .match    (match),
        .entries  (entries)
    );

    assign bus.wb_addr = empty ? '0 : head.rd;
    assign bus.wb_data = empty ? '0 : head.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        idx          = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if ((k < int'(count)) && match[idx] && (bus.fwd_addr != '0)) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = entries[idx].data;
            end
        end
    end

endmodule

// File: tb/tb_alu_wb_queue.sv
// Directed bench for alu_wb_queue: reset, drain order, r0 discard, forwarding, flush, async reset.
module tb_alu_wb_queue;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_wb_queue_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) bus ();

    alu_wb_queue #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_rd    = rd;
        bus.in_data  = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.wb_ready = 1'b0;
        bus.fwd_addr = '0;
        drive(1'b0, 5'd0, 32'h0);

        // Reset state
        #12;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 0);
        chk("rst_wb_addr", 32'(bus.wb_addr), 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_fwd_hit", 32'(bus.fwd_hit), 0);
        chk("rst_fwd_data", bus.fwd_data, 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        #2 rst_n = 1'b1;
        tick();

        // Single write, one-cycle latency, then drained
        bus.wb_ready = 1'b1;
        drive(1'b1, 5'd3, 32'h0000_0007);
        #1 chk("single_no_bypass", 32'(bus.wb_valid), 0);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        #1;
        chk("single_wb_valid", 32'(bus.wb_valid), 1);
        chk("single_wb_addr", 32'(bus.wb_addr), 3);
        chk("single_wb_data", bus.wb_data, 32'h7);
        tick();
        chk("single_count_after", 32'(bus.count), 0);
        chk("single_valid_after", 32'(bus.wb_valid), 0);

        // Fill under backpressure; pointers start at 1 so the queue wraps
        bus.wb_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'(i * 32'h11));
            tick();
        end
        drive(1'b0, 5'd0, 32'h0);
        #1;
        chk("fill_count", 32'(bus.count), 4);
        chk("fill_in_ready", 32'(bus.in_ready), 0);
        chk("fill_head", bus.wb_data, 32'h11);
        bus.wb_ready = 1'b1;
        drive(1'b1, 5'd6, 32'h55);
        #1 chk("full_drain_in_ready", 32'(bus.in_ready), 1);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        #1 chk("full_push_count", 32'(bus.count), 4);
        chk("drain_1", bus.wb_data, 32'h22);
        tick();
        chk("drain_2", bus.wb_data, 32'h33);
        tick();
        chk("drain_3", bus.wb_data, 32'h44);
        tick();
        chk("drain_4_wrap", bus.wb_data, 32'h55);
        chk("drain_4_addr", 32'(bus.wb_addr), 6);
        tick();
        chk("drain_empty", 32'(bus.count), 0);

        // Register 0 discard
        bus.wb_ready = 1'b0;
        drive(1'b1, 5'd0, 32'hDEAD_BEEF);
        #1 chk("r0_in_ready", 32'(bus.in_ready), 1);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        #1;
        chk("r0_count", 32'(bus.count), 0);
        chk("r0_wb_valid", 32'(bus.wb_valid), 0);
        bus.fwd_addr = 5'd0;
        #1 chk("r0_fwd_hit", 32'(bus.fwd_hit), 0);

        // Forward youngest of duplicates
        bus.fwd_addr = 5'd5;
        drive(1'b1, 5'd5, 32'hA);
        tick();
        drive(1'b1, 5'd5, 32'hB);
        #1 chk("fwd_enq_invisible", bus.fwd_data, 32'hA);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        #1;
        chk("fwd_hit", 32'(bus.fwd_hit), 1);
        chk("fwd_youngest", bus.fwd_data, 32'hB);
        bus.fwd_addr = 5'd9;
        #1;
        chk("fwd_miss_hit", 32'(bus.fwd_hit), 0);
        chk("fwd_miss_data", bus.fwd_data, 0);
        bus.fwd_addr = 5'd5;
        bus.wb_ready = 1'b1;
        #1 chk("dup_wb_first", bus.wb_data, 32'hA);
        tick();
        chk("dup_wb_second", bus.wb_data, 32'hB);
        chk("fwd_while_deq_hit", 32'(bus.fwd_hit), 1);
        chk("fwd_while_deq_data", bus.fwd_data, 32'hB);
        tick();
        chk("dup_empty", 32'(bus.count), 0);
        chk("fwd_after_drain", 32'(bus.fwd_hit), 0);

        // Flush overrides same-cycle enqueue
        bus.wb_ready = 1'b0;
        drive(1'b1, 5'd1, 32'h1);
        tick();
        drive(1'b1, 5'd2, 32'h2);
        tick();
        bus.flush = 1'b1;
        drive(1'b1, 5'd7, 32'h77);
        #1 chk("flush_in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        bus.fwd_addr = 5'd7;
        #1;
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_wb_valid", 32'(bus.wb_valid), 0);
        chk("flush_fwd_hit", 32'(bus.fwd_hit), 0);

        // Async reset mid-drain
        drive(1'b1, 5'd10, 32'h100);
        tick();
        drive(1'b1, 5'd11, 32'h110);
        tick();
        drive(1'b1, 5'd12, 32'h120);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        bus.wb_ready = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wb_valid", 32'(bus.wb_valid), 0);
        chk("arst_count", 32'(bus.count), 0);
        chk("arst_wb_data", bus.wb_data, 0);
        #3 rst_n = 1'b1;
        tick();
        drive(1'b1, 5'd2, 32'h5);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        #1;
        chk("post_rst_valid", 32'(bus.wb_valid), 1);
        chk("post_rst_addr", 32'(bus.wb_addr), 2);
        chk("post_rst_data", bus.wb_data, 32'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
